// File: rtl/ddr4_iod_dly_ctrl.sv
// ddr4_iod_dly_ctrl
//   Per-lane delay-line step controller for PolarFire DDR4 output IODs
//   (CKE, CA, CS). Converts training requests ("load" or "step N taps up or
//   down") into correctly spaced single-cycle MOVE/LOAD pulses for the IOD,
//   tracks the current tap, and aborts on the IOD out-of-range flag.
//
// Ports
//   FAB_CLK                 fabric clock, same as IOD TX_CLK
//   ARST_N                  asynchronous active-low reset
//   REQ_VALID/REQ_READY     request handshake, accepted on VALID & READY
//   REQ_LOAD                reload delay line to RESET_TAP (DIR/STEPS ignored)
//   REQ_DIR                 1 = increment delay, 0 = decrement
//   REQ_STEPS               number of taps to move (0 legal)
//   DONE                    1-cycle pulse when the request finishes
//   ERR                     1-cycle pulse with DONE when aborted at a range limit
//   TAP_CNT                 current tap position
//   DELAY_LINE_MOVE/DIRECTION/LOAD   to IOD
//   DELAY_LINE_OUT_OF_RANGE          from IOD
module ddr4_iod_dly_ctrl #(
    parameter int TAP_W     = 8,
    parameter int RESET_TAP = 1,
    parameter int MAX_TAP   = 255,
    parameter int STEP_GAP  = 3
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic             REQ_DIR,
    input  logic [TAP_W-1:0] REQ_STEPS,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] TAP_CNT,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int GW = (STEP_GAP < 2) ? 1 : $clog2(STEP_GAP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        MOVE  = 3'd2,
        GAP   = 3'd3,
        LDP   = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [TAP_W-1:0] rem;          // steps still to be pulsed
    logic [GW-1:0]    gap_cnt;      // GAP cycles left after the current one
    logic             is_load;      // current request is a LOAD
    logic             oor_seen;     // OUT_OF_RANGE seen earlier in this GAP
    logic             err_flag;     // abort decided on the edge into FIN
    logic             to_err;
    logic             tap_upd;
    logic             accept;
    logic             gap_last;
    logic             oor_hit;
    logic [TAP_W-1:0] tap_stepped;

    assign accept      = (state == IDLE) && REQ_VALID;
    assign gap_last    = (state == GAP) && (gap_cnt == '0);
    assign oor_hit     = oor_seen || DELAY_LINE_OUT_OF_RANGE;
    assign tap_stepped = DELAY_LINE_DIRECTION ? TAP_CNT + 1'b1 : TAP_CNT - 1'b1;

    function automatic logic at_limit(input logic dir, input logic [TAP_W-1:0] tap);
        return dir ? (tap == TAP_W'(MAX_TAP)) : (tap == '0);
    endfunction

    // Outputs are decoded from state so they fall with the async reset.
    assign REQ_READY       = (state == IDLE);
    assign DELAY_LINE_MOVE = (state == MOVE);
    assign DELAY_LINE_LOAD = (state == LDP);
    assign DONE            = (state == FIN);
    assign ERR             = (state == FIN) && err_flag;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        to_err    = 1'b0;
        tap_upd   = 1'b0;
        case (state)
            IDLE:  if (REQ_VALID) state_nxt = REQ_LOAD ? LDP : SETUP;
            SETUP: begin
                if (rem == '0) begin
                    state_nxt = FIN;
                end else if (at_limit(DELAY_LINE_DIRECTION, TAP_CNT)) begin
                    state_nxt = FIN;
                    to_err    = 1'b1;
                end else begin
                    state_nxt = MOVE;
                end
            end
            MOVE:  state_nxt = GAP;
            LDP:   state_nxt = GAP;
            GAP: begin
                if (gap_cnt == '0) begin
                    if (is_load) begin
                        state_nxt = FIN;
                        to_err    = oor_hit;
                    end else if (oor_hit) begin
                        state_nxt = FIN;
                        to_err    = 1'b1;
                    end else begin
                        tap_upd = 1'b1;
                        // Limit check for the next MOVE uses the post-step tap.
                        if (rem == '0) begin
                            state_nxt = FIN;
                        end else if (at_limit(DELAY_LINE_DIRECTION, tap_stepped)) begin
                            state_nxt = FIN;
                            to_err    = 1'b1;
                        end else begin
                            state_nxt = MOVE;
                        end
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            TAP_CNT              <= TAP_W'(RESET_TAP);
            DELAY_LINE_DIRECTION <= 1'b0;
            err_flag             <= 1'b0;
            oor_seen             <= 1'b0;
        end else begin
            if (accept && !REQ_LOAD) DELAY_LINE_DIRECTION <= REQ_DIR;
            if (gap_last && is_load) TAP_CNT <= TAP_W'(RESET_TAP);
            else if (tap_upd)        TAP_CNT <= tap_stepped;
            err_flag <= to_err;
            oor_seen <= (state == GAP) ? oor_hit : 1'b0;
        end
    end

    // Request/sequencing datapath
    always_ff @(posedge FAB_CLK) begin
        if (accept) begin
            rem     <= REQ_STEPS;
            is_load <= REQ_LOAD;
        end
        if (state == MOVE) rem <= rem - 1'b1;
        if (state == MOVE || state == LDP) gap_cnt <= GW'(STEP_GAP - 1);
        else if (state == GAP)             gap_cnt <= gap_cnt - 1'b1;
    end

endmodule

// File: tb/tb_ddr4_iod_dly_ctrl.sv
module tb_ddr4_iod_dly_ctrl;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N  = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic       REQ_LOAD = 1'b0;
    logic       REQ_DIR  = 1'b0;
    logic [7:0] REQ_STEPS = '0;
    logic       DONE, ERR;
    logic [7:0] TAP_CNT;
    logic       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;

    int compared = 0;
    int mismatched = 0;

    ddr4_iod_dly_ctrl #(.TAP_W(8), .RESET_TAP(1), .MAX_TAP(255), .STEP_GAP(3)) dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_LOAD(REQ_LOAD),
        .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS),
        .DONE(DONE), .ERR(ERR), .TAP_CNT(TAP_CNT),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic chk(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    // Issue one request and follow it to DONE. Cycle c=1 is the cycle after
    // the accept edge. oor_after: raise OUT_OF_RANGE in the cycle after that
    // MOVE number (0 = never).
    task automatic run_req(input string name, input logic load, input logic dir,
                           input int steps, input int oor_after,
                           input int exp_moves, input int exp_done_c,
                           input int exp_err, input int exp_tap);
        int  c, done_c, nmove, nload, load_c, err_v, tap_v;
        int  bad_ovl, bad_dir, bad_space;
        logic oor_pend;
        c = 0; done_c = 0; nmove = 0; nload = 0; load_c = 0; err_v = 0; tap_v = 0;
        bad_ovl = 0; bad_dir = 0; bad_space = 0; oor_pend = 1'b0;
        tick();
        chk({name, "_ready"}, int'(REQ_READY), 1);
        REQ_VALID = 1'b1; REQ_LOAD = load; REQ_DIR = dir; REQ_STEPS = 8'(steps);
        while (done_c == 0 && c < 100) begin
            tick();
            c++;
            if (c == 1) REQ_VALID = 1'b0;
            DELAY_LINE_OUT_OF_RANGE = oor_pend;
            oor_pend = 1'b0;
            if (int'(DELAY_LINE_MOVE) + int'(DELAY_LINE_LOAD) + int'(DONE) > 1) bad_ovl++;
            if (ERR && !DONE) bad_ovl++;
            if (!load && DELAY_LINE_DIRECTION !== dir) bad_dir++;
            if (DELAY_LINE_LOAD) begin nload++; load_c = c; end
            if (DELAY_LINE_MOVE) begin
                if (c != 2 + nmove * 4) bad_space++;
                nmove++;
                if (nmove == oor_after) oor_pend = 1'b1;
            end
            if (DONE) begin done_c = c; err_v = int'(ERR); tap_v = int'(TAP_CNT); end
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        chk({name, "_done_cycle"}, done_c, exp_done_c);
        chk({name, "_err"}, err_v, exp_err);
        chk({name, "_tap"}, tap_v, exp_tap);
        chk({name, "_moves"}, nmove, exp_moves);
        chk({name, "_loads"}, nload, load ? 1 : 0);
        if (load) chk({name, "_load_cycle"}, load_c, 1);
        chk({name, "_overlap"}, bad_ovl, 0);
        chk({name, "_dir"}, bad_dir, 0);
        chk({name, "_spacing"}, bad_space, 0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ready", int'(REQ_READY), 1);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_move", int'(DELAY_LINE_MOVE), 0);
        chk("rst_load", int'(DELAY_LINE_LOAD), 0);
        chk("rst_dir", int'(DELAY_LINE_DIRECTION), 0);
        chk("rst_tap", int'(TAP_CNT), 1);
        ARST_N = 1'b1;

        // LOAD: pulse in c1, DONE in c5, tap 1
        run_req("load", 1'b1, 1'b0, 0, 0, 0, 5, 0, 1);
        // up 5 from tap 1: DONE at c22, tap 6
        run_req("up5", 1'b0, 1'b1, 5, 0, 5, 22, 0, 6);
        // down 4 from 6 -> tap 2, DONE at c18
        run_req("dn4", 1'b0, 1'b0, 4, 0, 4, 18, 0, 2);
        // down 5 from 2: two moves, then limit at 0 -> FIN at c10 with ERR
        run_req("dn_lim", 1'b0, 1'b0, 5, 0, 2, 10, 1, 0);
        // reload, then up 10 with out-of-range in the GAP after move 3
        run_req("load2", 1'b1, 1'b1, 0, 0, 0, 5, 0, 1);
        run_req("oor", 1'b0, 1'b1, 10, 3, 3, 14, 1, 3);
        // N=0 request: DONE at c2, no move
        run_req("n0", 1'b0, 1'b1, 0, 0, 0, 2, 0, 3);

        // back-to-back: VALID held through first request, fields change after accept
        tick();
        REQ_VALID = 1'b1; REQ_LOAD = 1'b0; REQ_DIR = 1'b0; REQ_STEPS = 8'd0;
        tick();                                   // c1 of first (N=0, dir 0)
        REQ_DIR = 1'b1; REQ_STEPS = 8'd1;
        chk("b2b_busy", int'(REQ_READY), 0);
        chk("b2b_dir0", int'(DELAY_LINE_DIRECTION), 0);
        tick();                                   // c2: DONE of first
        chk("b2b_done1", int'(DONE), 1);
        chk("b2b_nomove", int'(DELAY_LINE_MOVE), 0);
        tick();                                   // c3: IDLE, second accepted at next edge
        chk("b2b_ready", int'(REQ_READY), 1);
        tick();                                   // SETUP of second
        REQ_VALID = 1'b0;
        chk("b2b_accepted", int'(REQ_READY), 0);
        chk("b2b_dir1", int'(DELAY_LINE_DIRECTION), 1);
        tick();
        chk("b2b_move", int'(DELAY_LINE_MOVE), 1);
        repeat (4) tick();
        chk("b2b_done2", int'(DONE), 1);
        chk("b2b_tap", int'(TAP_CNT), 4);

        // async reset during a GAP
        tick();
        REQ_VALID = 1'b1; REQ_DIR = 1'b1; REQ_STEPS = 8'd5;
        tick();                                   // SETUP
        REQ_VALID = 1'b0;
        tick();                                   // MOVE
        chk("ar_move_before", int'(DELAY_LINE_MOVE), 1);
        tick();                                   // GAP
        #1 ARST_N = 1'b0;
        #1;
        chk("ar_move", int'(DELAY_LINE_MOVE), 0);
        chk("ar_done", int'(DONE), 0);
        chk("ar_tap", int'(TAP_CNT), 1);
        #1 ARST_N = 1'b1;
        tick();
        chk("ar_ready", int'(REQ_READY), 1);
        chk("ar_tap_after", int'(TAP_CNT), 1);
        tick();
        chk("ar_idle_move", int'(DELAY_LINE_MOVE), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
